// File: rtl/lsq_issue_scheduler_pkg.sv
// Shared types for the load/store queue issue scheduler.
package lsq_issue_scheduler_pkg;

   // Scheduler arbitration mode.
   typedef enum logic [1:0] {
      LOAD_PRI    = 2'd0,
      STORE_BURST = 2'd1,
      FENCE       = 2'd2
   } lsq_sched_state_t;

endpackage

// File: rtl/lsq_issue_scheduler.sv
// Picks the load-queue head or store-queue head for issue each cycle.
// Loads win by default; stores get forward progress via a starvation
// counter and a full-queue drain burst, and a fence empties the store queue.
module lsq_issue_scheduler
   import lsq_issue_scheduler_pkg::*;
#(
   parameter int unsigned STORE_STARVE_LIMIT = 8,
   parameter int unsigned DRAIN_BURST        = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic load_valid,
   input  logic load_conflict,
   input  logic store_valid,
   input  logic sq_full,
   input  logic sq_empty,
   input  logic issue_ready,
   input  logic drain_req,
   output logic lsq_valid,
   output logic load_selected,
   output logic load_pop,
   output logic store_pop,
   output logic drain_done,
   output logic tr_store_starve
);

   localparam int unsigned CNT_MAX = (STORE_STARVE_LIMIT > DRAIN_BURST) ? STORE_STARVE_LIMIT : DRAIN_BURST;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STORE_STARVE_LIMIT);
   localparam logic [CNT_W-1:0] BURST_LEN  = CNT_W'(DRAIN_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   lsq_sched_state_t state_q, state_next;
   logic [CNT_W-1:0] starve_q, starve_next;
   logic [CNT_W-1:0] burst_q, burst_next;
   logic             drain_done_q, drain_done_next;

   logic load_ok;
   logic active;
   logic starve_hit;

   assign load_ok    = load_valid & ~load_conflict;
   assign active     = ~rst & ~flush;
   assign starve_hit = (starve_q == STARVE_MAX);

   // State, counters and registered drain status; flush behaves like reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LOAD_PRI;
         starve_q     <= '0;
         burst_q      <= '0;
         drain_done_q <= 1'b0;
      end else if (flush) begin
         state_q      <= LOAD_PRI;
         starve_q     <= '0;
         burst_q      <= '0;
         drain_done_q <= 1'b0;
      end else begin
         state_q      <= state_next;
         starve_q     <= starve_next;
         burst_q      <= burst_next;
         drain_done_q <= drain_done_next;
      end
   end

   // Next-state and counter updates; a fence request overrides every other move.
   always_comb begin
      state_next      = state_q;
      starve_next     = starve_q;
      burst_next      = burst_q;
      drain_done_next = 1'b0;
      case (state_q)
         LOAD_PRI: begin
            if (store_pop || !store_valid) begin
               starve_next = '0;
            end else if (load_pop && !starve_hit) begin
               starve_next = starve_q + CNT_ONE;
            end
            if (drain_req) begin
               state_next = FENCE;
            end else if (store_valid && (sq_full || starve_hit)) begin
               state_next  = STORE_BURST;
               burst_next  = '0;
               starve_next = '0;
            end
         end
         STORE_BURST: begin
            if (store_pop) begin
               burst_next = burst_q + CNT_ONE;
            end
            if (drain_req) begin
               state_next = FENCE;
               burst_next = '0;
            end else if ((store_pop && ((burst_q + CNT_ONE) == BURST_LEN)) ||
                         (!store_valid && !sq_full)) begin
               state_next = LOAD_PRI;
               burst_next = '0;
            end
         end
         FENCE: begin
            drain_done_next = drain_req & sq_empty & ~store_valid;
            if (!drain_req) begin
               state_next = LOAD_PRI;
            end
         end
         default: begin
            state_next = LOAD_PRI;
         end
      endcase
   end

   // Combinational selection and pop strobes, forced quiet during reset/flush.
   always_comb begin
      lsq_valid       = 1'b0;
      load_selected   = 1'b0;
      load_pop        = 1'b0;
      store_pop       = 1'b0;
      drain_done      = 1'b0;
      tr_store_starve = 1'b0;
      if (active) begin
         case (state_q)
            LOAD_PRI: begin
               load_selected   = load_ok;
               lsq_valid       = load_ok | store_valid;
               tr_store_starve = ~drain_req & store_valid & starve_hit & ~sq_full;
            end
            STORE_BURST, FENCE: begin
               load_selected = 1'b0;
               lsq_valid     = store_valid;
            end
            default: begin
               lsq_valid = 1'b0;
            end
         endcase
         load_pop   = lsq_valid & load_selected & issue_ready;
         store_pop  = lsq_valid & ~load_selected & store_valid & issue_ready;
         drain_done = drain_done_q & drain_req;
      end
   end

endmodule
